// File: rtl/regfile_sequencer.sv
// regfile_sequencer: access controller in front of a registered-read register
// file. Merges single-cycle host writes with a full-bank read-out scan that
// streams every register, tagged with its address, in ascending order.
// A host write always owns the register file slot. A scan read waits for a
// free slot, so the scan never skips an address.
module regfile_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int SCAN_LAST = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              scan_valid,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_done,
  output logic [ADDR_W-1:0] rf_address,
  output logic              rf_en_write,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(SCAN_LAST);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_vld_p0;
  logic                r_vld_p1;
  logic [ADDR_W-1:0]   r_addr_p1;
  logic                r_wr_ack;
  logic                r_busy;
  logic                r_scan_valid;
  logic [ADDR_W-1:0]   r_scan_addr;
  logic [DATA_W-1:0]   r_scan_data;
  logic                r_scan_done;
  logic [ADDR_W-1:0]   r_rf_addr;
  logic                r_rf_we;
  logic [DATA_W-1:0]   r_rf_din;

  logic w_issue;
  logic w_ptr_last;
  logic w_emit_last;

  // A scan read takes the slot only when no host write claims it.
  assign w_issue     = (r_state == S_SCAN) && !wr_req;
  assign w_ptr_last  = (r_ptr == LAST_A);
  assign w_emit_last = r_vld_p1 && (r_addr_p1 == LAST_A);

  assign wr_ack      = r_wr_ack;
  assign scan_busy   = r_busy;
  assign scan_valid  = r_scan_valid;
  assign scan_addr   = r_scan_addr;
  assign scan_data   = r_scan_data;
  assign scan_done   = r_scan_done;
  assign rf_address  = r_rf_addr;
  assign rf_en_write = r_rf_we;
  assign rf_data_in  = r_rf_din;

  // Slot arbitration, read pipeline and scan FSM with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_vld_p0     <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_addr_p1    <= '0;
      r_wr_ack     <= 1'b0;
      r_busy       <= 1'b0;
      r_scan_valid <= 1'b0;
      r_scan_addr  <= '0;
      r_scan_data  <= '0;
      r_scan_done  <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_we      <= 1'b0;
      r_rf_din     <= '0;
    end else begin
      // Stage 0: drive the register file pins (write wins, else scan read).
      r_wr_ack <= wr_req;
      r_rf_we  <= wr_req;
      if (wr_req) begin
        r_rf_addr <= wr_addr;
        r_rf_din  <= wr_data;
      end else if (w_issue) begin
        r_rf_addr <= r_ptr;
      end
      r_vld_p0 <= w_issue;

      // Stage 1: the register file presents read data during this cycle.
      r_vld_p1  <= r_vld_p0;
      r_addr_p1 <= r_rf_addr;

      // Stage 2: capture the word; the post-write 0x00 never carries a valid flag.
      r_scan_valid <= r_vld_p1;
      if (r_vld_p1) begin
        r_scan_addr <= r_addr_p1;
        r_scan_data <= rf_data_out;
      end

      r_scan_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (scan_start && !r_busy) begin
            r_state <= S_SCAN;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_issue) begin
            if (w_ptr_last) r_state <= S_DRAIN;
            else            r_ptr   <= r_ptr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_emit_last) begin
            r_scan_done <= 1'b1;
            r_state     <= S_IDLE;
            r_ptr       <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file, a transaction-level
// reference model of the slot/scan rules, directed scenarios and random traffic.
module tb_regfile_sequencer;

  logic       clock;
  logic       reset_n;
  logic       wr_req;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       scan_start;
  logic       scan_busy;
  logic       scan_valid;
  logic [3:0] scan_addr;
  logic [7:0] scan_data;
  logic       scan_done;
  logic [3:0] rf_address;
  logic       rf_en_write;
  logic [7:0] rf_data_in;
  logic [7:0] rf_data_out;

  regfile_sequencer #(.ADDR_W(4), .DATA_W(8), .SCAN_LAST(15)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_addr(scan_addr), .scan_data(scan_data), .scan_done(scan_done),
    .rf_address(rf_address), .rf_en_write(rf_en_write), .rf_data_in(rf_data_in),
    .rf_data_out(rf_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: registered read, returns 0x00 after a write cycle.
  logic [7:0] rf_mem [16];
  always @(posedge clock) begin
    if (rf_en_write) begin
      rf_mem[rf_address] <= rf_data_in;
      rf_data_out        <= 8'h00;
    end else begin
      rf_data_out        <= rf_mem[rf_address];
    end
  end

  // Reference model: expected pin activity and stream words per cycle.
  typedef struct { int due; int a; int d; } wexp_t;
  wexp_t q[$];
  int    edge_k;
  int    m_phase;   // 0 idle, 1 issuing reads, 2 waiting for last word
  int    m_next;
  int    shadow [16];
  bit    pw_v;
  int    pw_a, pw_d;
  bit    m_ack, m_en, m_rd, m_vld, m_done, m_busy;
  int    m_wa, m_wd, m_ra, m_sa, m_sd;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_phase = 0; m_next = 0; pw_v = 0;
      m_ack = 0; m_en = 0; m_rd = 0; m_vld = 0; m_done = 0; m_busy = 0;
      m_wa = 0; m_wd = 0; m_ra = 0; m_sa = 0; m_sd = 0;
    end else begin
      wexp_t w;
      edge_k++;
      if (pw_v) shadow[pw_a] = pw_d;
      pw_v  = 0;
      m_ack = wr_req;
      m_en  = wr_req;
      if (wr_req) begin
        m_wa = wr_addr; m_wd = wr_data;
        pw_v = 1; pw_a = wr_addr; pw_d = wr_data;
      end
      m_rd = 0;
      if (m_phase == 1 && !wr_req) begin
        m_rd = 1;
        m_ra = m_next;
        q.push_back('{due: edge_k + 2, a: m_next, d: shadow[m_next]});
        if (m_next == 15) m_phase = 2;
        else              m_next++;
      end
      m_vld = 0; m_done = 0;
      if (q.size() > 0 && q[0].due == edge_k) begin
        w = q.pop_front();
        m_vld = 1; m_sa = w.a; m_sd = w.d;
        if (w.a == 15) begin
          m_done = 1; m_phase = 0; m_next = 0;
        end
      end
      if (m_phase == 0 && !m_busy && scan_start) m_phase = 1;
      m_busy = (m_phase != 0) || m_done;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int seen [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("wr_ack", wr_ack, m_ack);
    chk("rf_en_write", rf_en_write, m_en);
    if (m_en) begin
      chk("rf_address_wr", rf_address, m_wa);
      chk("rf_data_in", rf_data_in, m_wd);
    end else if (m_rd) begin
      chk("rf_address_rd", rf_address, m_ra);
    end
    chk("scan_valid", scan_valid, m_vld);
    if (m_vld) begin
      chk("scan_addr", scan_addr, m_sa);
      chk("scan_data", scan_data, m_sd);
    end
    chk("scan_done", scan_done, m_done);
    chk("scan_busy", scan_busy, m_busy);
    if (scan_valid === 1'b1) seen[scan_addr] = scan_data;
  endtask

  task automatic cyc(input bit wr, input int a, input int d, input bit st);
    wr_req = wr; wr_addr = a[3:0]; wr_data = d[7:0]; scan_start = st;
    @(negedge clock);
    check_outputs();
  endtask

  task automatic drain();
    int n = 0;
    while ((m_phase != 0 || m_busy) && n < 200) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("drain_bound", (n >= 200), 0);
    cyc(0, 0, 0, 0);
  endtask

  function automatic logic [31:0] all_outs();
    return {3'b0, wr_ack, scan_busy, scan_valid, scan_addr, scan_data, scan_done,
            rf_address, rf_en_write, rf_data_in};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 8'h00; shadow[i] = 0; seen[i] = -1;
    end
    edge_k = 0;
    reset_n = 1'b0; wr_req = 0; wr_addr = 0; wr_data = 0; scan_start = 0;
    repeat (3) @(negedge clock);
    chk("reset_outs", all_outs(), 0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk("post_reset_outs", all_outs(), 0);

    // Single write
    cyc(1, 3, 8'hA5, 0);
    chk("t2_ack", wr_ack, 1);
    chk("t2_addr", rf_address, 3);
    chk("t2_din", rf_data_in, 8'hA5);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Preload and plain scan
    for (int i = 0; i < 16; i++) cyc(1, i, 8'h10 + i, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t3_not_yet", scan_valid, 0);
    cyc(0, 0, 0, 0);
    chk("t3_first_vld", scan_valid, 1);
    chk("t3_first_addr", scan_addr, 0);
    drain();
    chk("t3_a15", seen[15], 8'h1F);

    // Write during scan, to an address not yet read
    cyc(0, 0, 0, 1);
    for (int j = 1; j <= 8; j++) cyc(j == 6, 9, 8'hEE, 0);
    drain();
    chk("t4_a9", seen[9], 8'hEE);
    chk("t4_a4", seen[4], 8'h14);

    // Write behind the scan plus an ignored start
    cyc(0, 0, 0, 1);
    for (int j = 1; j <= 6; j++) cyc(j == 6, 1, 8'h77, j == 6);
    drain();
    chk("t5_a1_old", seen[1], 8'h11);
    chk("t5_idle", scan_busy, 0);
    cyc(0, 0, 0, 1);
    drain();
    chk("t5_a1_new", seen[1], 8'h77);

    // Reset mid-scan
    cyc(0, 0, 0, 1);
    for (int j = 1; j <= 8; j++) cyc(0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_outs", all_outs(), 0);
    for (int j = 0; j < 4; j++) begin
      cyc(0, 0, 0, 0);
      chk("t6_held", all_outs(), 0);
    end
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t6_restart_addr", scan_addr, 0);
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 255),
          $urandom_range(0, 11) == 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
